mac_window_sequencer: RTL and testbench
=======================================

// Module: mac_window_sequencer
// PURPOSE
// Front/back end for addmulacc: buffers one TAPS-entry kernel and one TAPS-pixel window.
// Streams (weight, pixel) pairs to the MAC one per cycle.
// Captures the MAC result on done and hands it downstream via valid/ready.
// Sits between the line-buffer/window generator and the addmulacc datapath.
// PARAMETERS
// DATA_W   8    width of kernel_weights / in_pix
// TAPS     9    operands per window (3x3 kernel)
// ACC_W    17   width of MAC result (out_pix)
// TIMEOUT  32   max cycles to wait for mac_done after last operand
// PORTS
// clk          in   1        rising-edge clock
// rst          in   1        asynchronous, active-high reset
// wt_wr_en     in   1        kernel weight write strobe
// wt_wr_addr   in   4        weight index, 0..TAPS-1
// wt_wr_data   in   DATA_W   weight value
// wt_ready     out  1        weight writes accepted when 1
// pix_valid    in   1        window pixel valid (raster order, tap 0 first)
// pix_data     in   DATA_W   window pixel
// pix_ready    out  1        sequencer accepts pixel
// kernel_weights out DATA_W  weight operand to MAC
// in_pix       out  DATA_W   pixel operand to MAC
// mac_valid    out  1        operand pair valid this cycle
// mac_first    out  1        first pair of window (MAC clears accumulator)
// mac_last     out  1        last pair of window
// mac_out_pix  in   ACC_W    MAC result
// mac_done     in   1        MAC result valid (single-cycle pulse)
// result_valid out  1        result available
// result_data  out  ACC_W    captured MAC result
// result_ready in   1        downstream accepts result
// err_timeout  out  1        sticky: mac_done missing within TIMEOUT
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, counters=0, weight and pixel buffers=0.
//   Every output is 0 except wt_ready=1 and pix_ready=1.
// - States: IDLE, LOAD, STREAM, WAIT, HOLD. All outputs are registered.
// - Weights: write occurs when wt_wr_en && wt_ready && wt_wr_addr<TAPS; others ignored.
//   wt_ready=0 only in STREAM. A weight write never affects the window being streamed.
// - Pixel handshake: pix_valid && pix_ready. pix_ready=1 in IDLE/LOAD only.
//   Accepted pixel k is stored to P[k].
//   First accept: IDLE->LOAD. TAPS-th accept (TAPS=1: first): ->STREAM next cycle.
// - STREAM: TAPS consecutive cycles, k=0..TAPS-1: kernel_weights=W[k], in_pix=P[k], mac_valid=1.
//   mac_first=1 at k=0, mac_last=1 at k=TAPS-1; no bubbles. Then ->WAIT.
//   Outside STREAM: mac_valid/first/last=0 and operands=0.
// - WAIT: on mac_done, result_data<=mac_out_pix and result_valid<=1 next cycle; ->HOLD.
//   If TIMEOUT cycles elapse without done: err_timeout<=1 (sticky until rst); ->IDLE, result dropped.
// - mac_done outside WAIT (incl. same cycle as entering WAIT from STREAM's final cycle): ignored.
// - HOLD: result_valid and result_data stable until result_ready=1. Then result_valid<=0; ->IDLE.
//   result_ready while result_valid=0 has no effect.
// - Latency: last pixel accepted at cycle N; pairs on N+1..N+TAPS.
//   WAIT from N+TAPS+1; result_valid one cycle after mac_done.
// - Back-to-back windows: next window loading starts in IDLE after result handshake.
// - Window counter wraps to 0 after each STREAM; weights persist across windows.
// - Arithmetic: no arithmetic on data; result passed through at ACC_W bits unchanged.
// TESTING
// 1 W=1..9 written, pixels 10..18 streamed with pix_valid held 1 -> 9 consecutive mac_valid cycles.
//   Pairs (1,10)..(9,18); mac_first on first, mac_last on last.
// 2 Model MAC returns done 3 cycles after mac_last with 0x0213 -> result_data=0x0213 held.
//   result_ready low 5 cycles then high -> single handshake, state IDLE.
// 3 pix_valid toggled 1/0 per cycle -> 9 pixels still captured in order.
//   STREAM starts the cycle after 9th accept.
// 4 wt_wr_en during STREAM (addr 0, data 0xFF) -> ignored, pair 0 weight stays 1.
//   wt_wr_addr=12 in IDLE -> no write.
// 5 No mac_done for 32 cycles in WAIT -> err_timeout=1, result_valid stays 0, pix_ready=1.
// 6 rst pulsed mid-STREAM (pair 4) -> immediately mac_valid=0, buffers 0, pix_ready=1, wt_ready=1.

Source files
------------

// File: rtl/mac_window_sequencer_if.sv
// Bundle of weight-write, pixel, MAC-operand and result signals around the window sequencer.
// No storage or latency of its own; every signal is a plain wire.
// Backpressure uses wt_ready / pix_ready / result_ready. The MAC side has none.
// Modports:
//   slave  : the sequencer itself (drives ready/operand/result outputs)
//   master : its environment (weight writer, window generator, MAC, result sink)
interface mac_window_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17
);
    logic              wt_wr_en;
    logic [3:0]        wt_wr_addr;
    logic [DATA_W-1:0] wt_wr_data;
    logic              wt_ready;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic [DATA_W-1:0] kernel_weights;
    logic [DATA_W-1:0] in_pix;
    logic              mac_valid;
    logic              mac_first;
    logic              mac_last;
    logic [ACC_W-1:0]  mac_out_pix;
    logic              mac_done;
    logic              result_valid;
    logic [ACC_W-1:0]  result_data;
    logic              result_ready;
    logic              err_timeout;

    modport slave (
        input  wt_wr_en, wt_wr_addr, wt_wr_data, pix_valid, pix_data,
               mac_out_pix, mac_done, result_ready,
        output wt_ready, pix_ready, kernel_weights, in_pix, mac_valid,
               mac_first, mac_last, result_valid, result_data, err_timeout
    );

    modport master (
        output wt_wr_en, wt_wr_addr, wt_wr_data, pix_valid, pix_data,
               mac_out_pix, mac_done, result_ready,
        input  wt_ready, pix_ready, kernel_weights, in_pix, mac_valid,
               mac_first, mac_last, result_valid, result_data, err_timeout
    );
endinterface

// File: rtl/mac_window_sequencer.sv
// Buffers a TAPS-entry kernel and TAPS-pixel window, streams (weight,pixel) pairs to the MAC, returns its result.
// Pairs appear on the TAPS cycles after the last pixel accept; result_valid rises one cycle after mac_done.
// pix_ready only in IDLE/LOAD, wt_ready low only while streaming; result held until result_ready.
// Ports: clk, rst (async, active high) and bus (mac_window_sequencer_if.slave) carrying
//   weight writes, pixel valid/ready, MAC operands/flags, MAC result/done, result valid/ready, err_timeout.
module mac_window_sequencer #(
    parameter int DATA_W  = 8,
    parameter int TAPS    = 9,
    parameter int ACC_W   = 17,
    parameter int TIMEOUT = 32
) (
    input logic                   clk,
    input logic                   rst,
    mac_window_sequencer_if.slave bus
);
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;      // pixel index while loading, pair index while streaming
    logic [TW-1:0]     tmr, tmr_nxt;      // cycles spent in WAIT
    logic [DATA_W-1:0] w_q   [TAPS];
    logic [DATA_W-1:0] w_nxt [TAPS];
    logic [DATA_W-1:0] p_q   [TAPS];
    logic [DATA_W-1:0] p_nxt [TAPS];

    logic              wt_ready_nxt, pix_ready_nxt;
    logic              mac_valid_nxt, mac_first_nxt, mac_last_nxt;
    logic [DATA_W-1:0] kw_nxt, ip_nxt;
    logic              result_valid_nxt, err_nxt;
    logic [ACC_W-1:0]  result_data_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tmr   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                w_q[i] <= '0;
                p_q[i] <= '0;
            end
            bus.wt_ready       <= 1'b1;
            bus.pix_ready      <= 1'b1;
            bus.kernel_weights <= '0;
            bus.in_pix         <= '0;
            bus.mac_valid      <= 1'b0;
            bus.mac_first      <= 1'b0;
            bus.mac_last       <= 1'b0;
            bus.result_valid   <= 1'b0;
            bus.result_data    <= '0;
            bus.err_timeout    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tmr   <= tmr_nxt;
            w_q   <= w_nxt;
            p_q   <= p_nxt;
            bus.wt_ready       <= wt_ready_nxt;
            bus.pix_ready      <= pix_ready_nxt;
            bus.kernel_weights <= kw_nxt;
            bus.in_pix         <= ip_nxt;
            bus.mac_valid      <= mac_valid_nxt;
            bus.mac_first      <= mac_first_nxt;
            bus.mac_last       <= mac_last_nxt;
            bus.result_valid   <= result_valid_nxt;
            bus.result_data    <= result_data_nxt;
            bus.err_timeout    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        tmr_nxt          = tmr;
        w_nxt            = w_q;
        p_nxt            = p_q;
        result_valid_nxt = bus.result_valid;
        result_data_nxt  = bus.result_data;
        err_nxt          = bus.err_timeout;
        wt_ready_nxt     = 1'b1;
        pix_ready_nxt    = 1'b0;
        kw_nxt           = '0;
        ip_nxt           = '0;
        mac_valid_nxt    = 1'b0;
        mac_first_nxt    = 1'b0;
        mac_last_nxt     = 1'b0;

        // wt_ready is low for the whole stream, so the kernel is frozen while pairs go out.
        if (bus.wt_wr_en && bus.wt_ready && (32'(bus.wt_wr_addr) < TAPS))
            w_nxt[bus.wt_wr_addr] = bus.wt_wr_data;

        unique case (state)
            IDLE, LOAD: begin
                if (bus.pix_valid && bus.pix_ready) begin
                    p_nxt[cnt] = bus.pix_data;
                    if (32'(cnt) == TAPS - 1) begin
                        state_nxt = STREAM;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = LOAD;
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
            end
            STREAM: begin
                if (32'(cnt) == TAPS - 1) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                    tmr_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT: begin
                // A done arriving in the final allowed cycle still wins over the timeout.
                if (bus.mac_done) begin
                    state_nxt        = HOLD;
                    result_valid_nxt = 1'b1;
                    result_data_nxt  = bus.mac_out_pix;
                end else if (32'(tmr) == TIMEOUT - 1) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    tmr_nxt = tmr + TW'(1);
                end
            end
            HOLD: begin
                if (bus.result_ready) begin
                    result_valid_nxt = 1'b0;
                    state_nxt        = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state. Operands come
        // from the next buffer contents so the pixel accepted on the entry edge is visible.
        pix_ready_nxt = (state_nxt == IDLE) || (state_nxt == LOAD);
        wt_ready_nxt  = (state_nxt != STREAM);
        if (state_nxt == STREAM) begin
            kw_nxt        = w_nxt[cnt_nxt];
            ip_nxt        = p_nxt[cnt_nxt];
            mac_valid_nxt = 1'b1;
            mac_first_nxt = (cnt_nxt == '0);
            mac_last_nxt  = (32'(cnt_nxt) == TAPS - 1);
        end
    end
endmodule

// File: tb/tb_mac_window_sequencer.sv
// Self-checking bench for mac_window_sequencer: table of window scenarios, hand-written
// reset/corner sequences, then randomized windows checked against a cycle-count reference model.
// The model keeps the kernel as an array and predicts results from the done delay alone.
module tb_mac_window_sequencer;
    localparam int DATA_W  = 8;
    localparam int TAPS    = 9;
    localparam int ACC_W   = 17;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_window_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    mac_window_sequencer #(
        .DATA_W(DATA_W), .TAPS(TAPS), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] wm [TAPS];   // reference kernel contents
    logic [DATA_W-1:0] px [TAPS];   // window currently being sent
    bit                err_m;       // reference sticky timeout flag

    typedef struct {
        int               gap;        // 0 held valid, 1 toggled, 2 random gaps
        int               done_dly;   // cycles after the mac_last cycle that done is driven
        logic [ACC_W-1:0] val;
        int               rdy_dly;
        bit               wr_stream;  // attempt a weight write mid-stream
        bit               exp_ok;
        bit               exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_w(input logic [3:0] a, input logic [DATA_W-1:0] d);
        chk("wt_ready_idle", 32'(bus.wt_ready), 32'd1);
        bus.wt_wr_en   = 1'b1;
        bus.wt_wr_addr = a;
        bus.wt_wr_data = d;
        tick();
        bus.wt_wr_en = 1'b0;
        if (a < TAPS) wm[a] = d;
    endtask

    task automatic feed_pixels(input int gap);
        int idle;
        for (int k = 0; k < TAPS; k++) begin
            idle = 0;
            if (gap == 1 && k > 0) idle = 1;
            else if (gap == 2) idle = $urandom_range(0, 2);
            repeat (idle) begin
                bus.pix_valid = 1'b0;
                // result_ready with no result pending must be harmless
                if (gap == 2) bus.result_ready = 1'($urandom_range(0, 1));
                tick();
                chk("no_ops_while_loading", 32'(bus.mac_valid), 32'd0);
            end
            bus.result_ready = 1'b0;
            chk("pix_ready_load", 32'(bus.pix_ready), 32'd1);
            bus.pix_valid = 1'b1;
            bus.pix_data  = px[k];
            tick();
        end
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
    endtask

    task automatic check_pair(input int c);
        chk($sformatf("pair%0d_mac_valid", c), 32'(bus.mac_valid), 32'd1);
        chk($sformatf("pair%0d_weight", c), 32'(bus.kernel_weights), 32'(wm[c]));
        chk($sformatf("pair%0d_pixel", c), 32'(bus.in_pix), 32'(px[c]));
        chk($sformatf("pair%0d_first", c), 32'(bus.mac_first), 32'(c == 0));
        chk($sformatf("pair%0d_last", c), 32'(bus.mac_last), 32'(c == TAPS - 1));
    endtask

    task automatic run_window(input int gap, input int d, input logic [ACC_W-1:0] val,
                              input int rdy, input bit wr, input bit exp_ok, input bit exp_err);
        bit done_seen;
        feed_pixels(gap);
        // pairs must occupy the TAPS cycles straight after the last accept
        for (int c = 0; c < TAPS; c++) begin
            check_pair(c);
            chk("wt_ready_stream", 32'(bus.wt_ready), 32'd0);
            chk("pix_ready_stream", 32'(bus.pix_ready), 32'd0);
            bus.wt_wr_en   = wr && (c == 2);
            bus.wt_wr_addr = 4'd0;
            bus.wt_wr_data = 8'hFF;
            if (c == TAPS - 1 && d == 0) begin
                bus.mac_done    = 1'b1;
                bus.mac_out_pix = val;
            end
            tick();
        end
        bus.wt_wr_en = 1'b0;
        bus.mac_done = 1'b0;
        chk("mac_valid_after_stream", 32'(bus.mac_valid), 32'd0);
        chk("weight_zero_after_stream", 32'(bus.kernel_weights), 32'd0);

        done_seen = 1'b0;
        for (int w = 1; w <= TIMEOUT && !done_seen; w++) begin
            chk("result_valid_wait", 32'(bus.result_valid), 32'd0);
            if (w == d) begin
                bus.mac_done    = 1'b1;
                bus.mac_out_pix = val;
            end
            tick();
            bus.mac_done = 1'b0;
            if (w == d) done_seen = 1'b1;
        end

        if (exp_ok) begin
            chk("result_valid_set", 32'(bus.result_valid), 32'd1);
            chk("result_data", 32'(bus.result_data), 32'(val));
            bus.mac_out_pix = ~val;  // later MAC output must not leak into the held result
            for (int r = 0; r < rdy; r++) begin
                tick();
                chk("result_valid_hold", 32'(bus.result_valid), 32'd1);
                chk("result_data_hold", 32'(bus.result_data), 32'(val));
            end
            bus.result_ready = 1'b1;
            tick();
            bus.result_ready = 1'b0;
            chk("result_valid_cleared", 32'(bus.result_valid), 32'd0);
        end else begin
            chk("result_valid_dropped", 32'(bus.result_valid), 32'd0);
        end
        chk("pix_ready_after_window", 32'(bus.pix_ready), 32'd1);
        chk("err_timeout", 32'(bus.err_timeout), 32'(exp_err));
    endtask

    initial begin
        int d;
        bit ok;
        int nw;

        rst              = 1'b1;
        bus.wt_wr_en     = 1'b0;
        bus.wt_wr_addr   = '0;
        bus.wt_wr_data   = '0;
        bus.pix_valid    = 1'b0;
        bus.pix_data     = '0;
        bus.mac_out_pix  = '0;
        bus.mac_done     = 1'b0;
        bus.result_ready = 1'b0;

        //             gap done  val          rdy wr ok err
        vecs[0] = '{0,   3,  17'h00213,   5,  0, 1, 0};
        vecs[1] = '{1,   1,  17'h1ABCD,   0,  0, 1, 0};
        vecs[2] = '{0,   32, 17'h00001,   1,  1, 1, 0};
        vecs[3] = '{1,   0,  17'h1FFFF,   0,  0, 0, 1};
        vecs[4] = '{0,   33, 17'h12345,   0,  0, 0, 1};
        vecs[5] = '{0,   2,  17'h0FF00,   2,  0, 1, 1};

        repeat (2) tick();
        chk("rst_mac_valid", 32'(bus.mac_valid), 32'd0);
        chk("rst_mac_first", 32'(bus.mac_first), 32'd0);
        chk("rst_mac_last", 32'(bus.mac_last), 32'd0);
        chk("rst_kernel_weights", 32'(bus.kernel_weights), 32'd0);
        chk("rst_in_pix", 32'(bus.in_pix), 32'd0);
        chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_result_data", 32'(bus.result_data), 32'd0);
        chk("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        chk("rst_wt_ready", 32'(bus.wt_ready), 32'd1);
        rst = 1'b0;
        tick();
        for (int i = 0; i < TAPS; i++) wm[i] = '0;
        err_m = 1'b0;

        for (int i = 0; i < TAPS; i++) write_w(4'(i), 8'(i + 1));

        for (int i = 0; i < 6; i++) begin
            if (i == 1) write_w(4'd12, 8'h55);  // out-of-range index must be dropped
            for (int k = 0; k < TAPS; k++)
                px[k] = (i == 0) ? 8'(10 + k) : 8'($urandom);
            run_window(vecs[i].gap, vecs[i].done_dly, vecs[i].val, vecs[i].rdy_dly,
                       vecs[i].wr_stream, vecs[i].exp_ok, vecs[i].exp_err);
        end

        // reset in the middle of a stream
        for (int k = 0; k < TAPS; k++) px[k] = 8'(3 * k + 1);
        feed_pixels(0);
        for (int c = 0; c <= 4; c++) begin
            check_pair(c);
            if (c < 4) tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_mac_valid", 32'(bus.mac_valid), 32'd0);
        chk("midrst_kernel_weights", 32'(bus.kernel_weights), 32'd0);
        chk("midrst_in_pix", 32'(bus.in_pix), 32'd0);
        chk("midrst_pix_ready", 32'(bus.pix_ready), 32'd1);
        chk("midrst_wt_ready", 32'(bus.wt_ready), 32'd1);
        chk("midrst_err_timeout", 32'(bus.err_timeout), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < TAPS; i++) wm[i] = '0;
        err_m = 1'b0;
        for (int k = 0; k < TAPS; k++) px[k] = 8'(200 + k);
        run_window(0, 5, 17'h0A5A5, 1, 1'b0, 1'b1, 1'b0);

        // randomized windows against the reference model
        for (int n = 0; n < 20; n++) begin
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) write_w(4'($urandom_range(0, 15)), 8'($urandom));
            for (int k = 0; k < TAPS; k++) px[k] = 8'($urandom);
            d  = $urandom_range(0, 36);
            ok = (d >= 1) && (d <= TIMEOUT);
            if (!ok) err_m = 1'b1;
            run_window(2, d, 17'($urandom), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), ok, err_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
